i2c_byte_master: RTL

//  Low-level I2C master that executes one command from the nunchuck driver FSM per start pulse.

---
 rtl/i2c_byte_master.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_byte_master.sv
// I2C byte master: runs one START / address / [register] / data x N / STOP command per start
// pulse, four i2c_clock ticks per SCL period; SDA is open-drain, SCL is push-pull.
module i2c_byte_master #(
    parameter int MAX_BYTES = 6,
    parameter int NBW       = $clog2(MAX_BYTES + 1)
) (
    input  logic                   i2c_clock,
    input  logic                   rst,
    input  logic                   disable_n0,
    input  logic [6:0]             device_addr,
    input  logic [7:0]             reg_addr,
    input  logic [NBW-1:0]         num_bytes,
    input  logic [MAX_BYTES*8-1:0] data_in,
    input  logic                   write,
    input  logic                   start,
    output logic [MAX_BYTES*8-1:0] data_out,
    output logic                   done,
    output logic                   nack,
    output logic                   busy,
    output logic                   scl,
    inout  wire                    sda
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, STOP, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             phase_q, phase_d;
    logic [2:0]             bit_q, bit_d;
    logic [NBW-1:0]         byte_q, byte_d;
    logic [NBW-1:0]         count_q, count_d;
    logic [7:0]             shift_q, shift_d;
    logic [6:0]             addr_q, addr_d;
    logic [7:0]             reg_q, reg_d;
    logic [MAX_BYTES*8-1:0] wdata_q, wdata_d;
    logic                   write_q, write_d;
    logic [MAX_BYTES*8-1:0] data_out_q, data_out_d;
    logic                   done_q, done_d;
    logic                   nack_q, nack_d;
    logic                   busy_q, busy_d;
    logic                   scl_q, scl_d;
    logic                   sda_low_q, sda_low_d;

    logic sda_in, slot_end, sample, last_byte, mid_slot;

    assign sda_in    = sda;
    assign sda       = sda_low_q ? 1'b0 : 1'bz;
    assign slot_end  = (phase_q == 2'd3);
    assign sample    = (phase_q == 2'd2);
    assign last_byte = (byte_q == count_q - NBW'(1));

    assign data_out = data_out_q;
    assign done     = done_q;
    assign nack     = nack_q;
    assign busy     = busy_q;
    assign scl      = scl_q;

    function automatic logic [7:0] byte_of(input logic [MAX_BYTES*8-1:0] vec,
                                           input logic [NBW-1:0]         idx);
        byte_of = '0;
        for (int k = 0; k < MAX_BYTES; k++)
            if (idx == NBW'(k)) byte_of = vec[8*k +: 8];
    endfunction

    function automatic logic [MAX_BYTES*8-1:0] put_byte(input logic [MAX_BYTES*8-1:0] vec,
                                                        input logic [NBW-1:0]         idx,
                                                        input logic [7:0]             val);
        put_byte = vec;
        for (int k = 0; k < MAX_BYTES; k++)
            if (idx == NBW'(k)) put_byte[8*k +: 8] = val;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        phase_d    = phase_q + 2'd1;
        bit_d      = bit_q;
        byte_d     = byte_q;
        count_d    = count_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        nack_d     = nack_q;
        busy_d     = busy_q;

        unique case (state_q)
            IDLE: begin
                phase_d = 2'd0;
                if (start && !disable_n0) begin
                    state_d = START;
                    busy_d  = 1'b1;
                    nack_d  = 1'b0;
                    addr_d  = device_addr;
                    reg_d   = reg_addr;
                    wdata_d = data_in;
                    write_d = write;
                    count_d = (num_bytes > NBW'(MAX_BYTES)) ? NBW'(MAX_BYTES) : num_bytes;
                    if (!write) data_out_d = '0;
                end
            end
            START: if (slot_end) begin
                state_d = ADDR;
                bit_d   = 3'd0;
                shift_d = {addr_q, ~write_q};
            end
            ADDR, REG, WDATA: if (slot_end) begin
                if (bit_q == 3'd7)
                    state_d = (state_q == ADDR) ? ADDR_ACK : (state_q == REG) ? REG_ACK : WDATA_ACK;
                else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {shift_q[6:0], 1'b0};
                end
            end
            ADDR_ACK, REG_ACK, WDATA_ACK: begin
                if (sample && sda_in) nack_d = 1'b1;
                // nack_q already holds this slot's ph2 sample by the time ph3 ends
                if (slot_end) begin
                    bit_d = 3'd0;
                    if (nack_q)
                        state_d = STOP;
                    else if (state_q == ADDR_ACK && write_q) begin
                        state_d = REG;
                        shift_d = reg_q;
                    end else if (count_q == '0 || (state_q == WDATA_ACK && last_byte))
                        state_d = STOP;
                    else if (state_q == ADDR_ACK) begin
                        state_d = RDATA;
                        byte_d  = '0;
                    end else begin
                        state_d = WDATA;
                        byte_d  = (state_q == REG_ACK) ? '0 : byte_q + NBW'(1);
                        shift_d = byte_of(wdata_q, byte_d);
                    end
                end
            end
            RDATA: begin
                if (sample) begin
                    shift_d = {shift_q[6:0], sda_in};
                    if (bit_q == 3'd7) data_out_d = put_byte(data_out_q, byte_q, shift_d);
                end
                if (slot_end) begin
                    if (bit_q == 3'd7) state_d = RDATA_ACK;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            RDATA_ACK: if (slot_end) begin
                if (last_byte) state_d = STOP;
                else begin
                    state_d = RDATA;
                    byte_d  = byte_q + NBW'(1);
                    bit_d   = 3'd0;
                end
            end
            STOP: if (slot_end) state_d = DONE;
            DONE: begin
                state_d = IDLE;
                phase_d = 2'd0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Line levels are decoded from the next state so the pins are driven straight from flops.
        mid_slot  = (phase_d == 2'd1) || (phase_d == 2'd2);
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        unique case (state_d)
            START: begin
                scl_d     = (phase_d != 2'd3);
                sda_low_d = phase_d[1];
            end
            ADDR, REG, WDATA: begin
                scl_d     = mid_slot;
                sda_low_d = ~shift_d[7];
            end
            ADDR_ACK, REG_ACK, WDATA_ACK, RDATA: scl_d = mid_slot;
            RDATA_ACK: begin
                scl_d     = mid_slot;
                sda_low_d = (byte_d != count_q - NBW'(1));
            end
            STOP: begin
                scl_d     = (phase_d != 2'd0);
                sda_low_d = ~phase_d[1];
            end
            default: ;
        endcase
    end

    // NOTE: the command latch is reset along with the control state so nothing starts out unknown.
    always_ff @(posedge i2c_clock or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= 2'd0;
            bit_q      <= 3'd0;
            byte_q     <= '0;
            count_q    <= '0;
            shift_q    <= 8'd0;
            addr_q     <= 7'd0;
            reg_q      <= 8'd0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            busy_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            busy_q     <= busy_d;
            scl_q      <= scl_d;
            sda_low_q  <= sda_low_d;
        end
    end

endmodule
